io_bus_master: RTL and testbench

- Processor-side initiator for the 5-bit-address, 8-bit-data memory-mapped IO port.
- Accepts single IO requests from the core's load/store stage via a valid/ready handshake:
  - read
  - write
  - bit-set (read-modify-write)
  - bit-clear (read-modify-write)
- Drives the peripheral's readaddr/readdata and writeaddr/writedata/write_en bus.
- Accounts for the peripheral's registered (1-cycle) read latency and returns a one-cycle completion pulse with data.

---
 rtl/io_bus_master.sv | 135 +++++++++++++
 tb/tb_io_bus_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_master.sv
// Initiator for the memory-mapped IO port: read, write and bit-set/clear
// read-modify-write requests, with registered bus outputs and a one-cycle completion pulse.
module io_bus_master #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [ADDR_WIDTH-1:0] readaddr,
   input  logic [DATA_WIDTH-1:0] readdata,
   output logic [ADDR_WIDTH-1:0] writeaddr,
   output logic [DATA_WIDTH-1:0] writedata,
   output logic                  write_en
);

   localparam int unsigned IdxWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [1:0] OpRead  = 2'b00;
   localparam logic [1:0] OpWrite = 2'b01;
   localparam logic [1:0] OpClr   = 2'b11;

   typedef enum logic [1:0] {StIdle, StRdWait, StRdData, StWr} state_e;

   state_e                r_state, w_state_d;
   logic [1:0]            r_op, w_op_d;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
   logic [IdxWidth-1:0]   r_idx, w_idx_d;
   logic [ADDR_WIDTH-1:0] r_readaddr, w_readaddr_d;
   logic [ADDR_WIDTH-1:0] r_writeaddr, w_writeaddr_d;
   logic [DATA_WIDTH-1:0] r_writedata, w_writedata_d;
   logic [DATA_WIDTH-1:0] r_resp_data, w_resp_data_d;
   logic                  r_write_en, w_write_en_d;
   logic                  r_resp_valid, w_resp_valid_d;
   logic [DATA_WIDTH-1:0] w_mask;
   logic [DATA_WIDTH-1:0] w_modified;

   assign w_mask     = DATA_WIDTH'(1) << r_idx;
   assign w_modified = (r_op == OpClr) ? (readdata & ~w_mask) : (readdata | w_mask);

   assign req_ready  = (r_state == StIdle) && !reset;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign readaddr   = r_readaddr;
   assign writeaddr  = r_writeaddr;
   assign writedata  = r_writedata;
   assign write_en   = r_write_en;

   always_comb begin
      w_state_d      = r_state;
      w_op_d         = r_op;
      w_addr_d       = r_addr;
      w_idx_d        = r_idx;
      w_readaddr_d   = r_readaddr;
      w_writeaddr_d  = r_writeaddr;
      w_writedata_d  = r_writedata;
      w_resp_data_d  = r_resp_data;
      w_write_en_d   = 1'b0;
      w_resp_valid_d = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (req_valid) begin
               w_op_d   = req_op;
               w_addr_d = req_addr;
               w_idx_d  = req_data[IdxWidth-1:0];
               if (req_op == OpWrite) begin
                  w_writeaddr_d = req_addr;
                  w_writedata_d = req_data;
                  w_write_en_d  = 1'b1;
                  w_resp_data_d = req_data;
                  w_state_d     = StWr;
               end else begin
                  w_readaddr_d = req_addr;
                  w_state_d    = StRdWait;
               end
            end
         end
         StRdWait: w_state_d = StRdData;
         StRdData: begin
            if (r_op == OpRead) begin
               w_resp_data_d  = readdata;
               w_resp_valid_d = 1'b1;
               w_state_d      = StIdle;
            end else begin
               // Bit-op: write back the value read this edge; response follows the write
               w_writeaddr_d = r_addr;
               w_writedata_d = w_modified;
               w_write_en_d  = 1'b1;
               w_state_d     = StWr;
            end
         end
         StWr: begin
            if (r_op[1]) begin
               w_resp_data_d = r_writedata;
            end
            w_resp_valid_d = 1'b1;
            w_state_d      = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= StIdle;
         r_op         <= 2'b00;
         r_addr       <= '0;
         r_idx        <= '0;
         r_readaddr   <= '0;
         r_writeaddr  <= '0;
         r_writedata  <= '0;
         r_resp_data  <= '0;
         r_write_en   <= 1'b0;
         r_resp_valid <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_op         <= w_op_d;
         r_addr       <= w_addr_d;
         r_idx        <= w_idx_d;
         r_readaddr   <= w_readaddr_d;
         r_writeaddr  <= w_writeaddr_d;
         r_writedata  <= w_writedata_d;
         r_resp_data  <= w_resp_data_d;
         r_write_en   <= w_write_en_d;
         r_resp_valid <= w_resp_valid_d;
      end
   end

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: directed bus scenarios followed by a randomized request
// stream checked against a register-level reference model of the attached peripheral.
module tb_io_bus_master;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [4:0] req_addr;
   logic [7:0] req_data;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic [4:0] readaddr;
   logic [7:0] readdata;
   logic [4:0] writeaddr;
   logic [7:0] writedata;
   logic       write_en;

   io_bus_master #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .readaddr   (readaddr),
      .readdata   (readdata),
      .writeaddr  (writeaddr),
      .writedata  (writedata),
      .write_en   (write_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Peripheral: 0 = {switches,keys} (read-only), 1 = LEDs, 2..15 scratch, rest unmapped
   logic       p_rst;
   logic [3:0] sw, keys, leds;
   logic [7:0] p_regs [16];

   always_ff @(posedge clk) begin
      if (p_rst) begin
         leds <= '0;
         for (int i = 0; i < 16; i++) p_regs[i] <= '0;
      end else if (write_en) begin
         if (writeaddr == 5'd1) leds <= writedata[3:0];
         else if (writeaddr >= 5'd2 && writeaddr < 5'd16) p_regs[writeaddr[3:0]] <= writedata;
      end
      if (readaddr == 5'd0)     readdata <= {sw, keys};
      else if (readaddr == 5'd1) readdata <= {4'h0, leds};
      else if (readaddr < 5'd16) readdata <= p_regs[readaddr[3:0]];
      else                       readdata <= 8'h00;
   end

   // Reference model of the register file as the core sees it
   logic [3:0] ref_led;
   logic [7:0] ref_regs [16];

   function automatic logic [7:0] ref_rd(input logic [4:0] a);
      if (a == 5'd0) return {sw, keys};
      if (a == 5'd1) return {4'h0, ref_led};
      if (a < 5'd16) return ref_regs[a[3:0]];
      return 8'h00;
   endfunction

   function automatic void ref_wr(input logic [4:0] a, input logic [7:0] v);
      if (a == 5'd1) ref_led = v[3:0];
      else if (a >= 5'd2 && a < 5'd16) ref_regs[a[3:0]] = v;
   endfunction

   function automatic logic [7:0] ref_exec(input logic [1:0] op, input logic [4:0] a,
                                           input logic [7:0] d);
      logic [7:0] v;
      case (op)
         2'd0: v = ref_rd(a);
         2'd1: begin v = d; ref_wr(a, v); end
         2'd2: begin v = ref_rd(a) | (8'd1 << d[2:0]); ref_wr(a, v); end
         default: begin v = ref_rd(a) & ~(8'd1 << d[2:0]); ref_wr(a, v); end
      endcase
      return v;
   endfunction

   function automatic int lat_of(input logic [1:0] op);
      if (op == 2'd0) return 3;
      if (op == 2'd1) return 2;
      return 4;
   endfunction

   int total, bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // One request from idle; reports response, negedges to resp_valid, write_en pulses
   task automatic do_req(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d,
                         output logic [7:0] rdata, output int lat, output int wcnt,
                         output logic [4:0] wa, output logic [7:0] wd);
      int guard;
      req_op    = op;
      req_addr  = a;
      req_data  = d;
      req_valid = 1'b1;
      guard     = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat   = 0;
      wcnt  = 0;
      wa    = '0;
      wd    = '0;
      rdata = 'x;
      do begin
         @(negedge clk);
         lat++;
         if (write_en) begin
            wcnt++;
            wa = writeaddr;
            wd = writedata;
         end
      end while (!resp_valid && lat < 12);
      if (resp_valid) rdata = resp_data;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] r_d, wd, exp_v;
   logic [4:0] wa;
   logic [1:0] p_op;
   logic [4:0] p_addr;
   logic [7:0] p_data;
   int         lat, wcnt, nacc, nresp, age, first_resp, second_resp, rcnt, cyc;
   logic       pend, ready_at_resp, accepting;
   logic [7:0] first_data, second_data;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      p_rst = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_addr  = '0;
      req_data  = '0;
      sw        = 4'h5;
      keys      = 4'h3;
      ref_led   = '0;
      for (int i = 0; i < 16; i++) ref_regs[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_wen", write_en, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_readaddr", readaddr, 0);
      chk("rst_writeaddr", writeaddr, 0);
      chk("rst_writedata", writedata, 0);
      chk("rst_resp_data", resp_data, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      p_rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);
      @(posedge clk);
      #1;

      // Write 0x0A to LEDs
      do_req(2'd1, 5'd1, 8'h0A, r_d, lat, wcnt, wa, wd);
      void'(ref_exec(2'd1, 5'd1, 8'h0A));
      chk("wr_resp", r_d, 8'h0A);
      chk("wr_lat", lat, 2);
      chk("wr_wen_cnt", wcnt, 1);
      chk("wr_waddr", wa, 5'd1);
      chk("wr_wdata", wd, 8'h0A);
      chk("wr_leds", leds, 4'hA);

      // Read switches/keys
      do_req(2'd0, 5'd0, 8'hFF, r_d, lat, wcnt, wa, wd);
      chk("rd_resp", r_d, 8'h53);
      chk("rd_lat", lat, 3);
      chk("rd_wen_cnt", wcnt, 0);

      // Bit-set idx 0, then bit-clear idx 3 on LEDs
      do_req(2'd2, 5'd1, 8'h00, r_d, lat, wcnt, wa, wd);
      void'(ref_exec(2'd2, 5'd1, 8'h00));
      chk("set_resp", r_d, 8'h0B);
      chk("set_wdata", wd, 8'h0B);
      chk("set_lat", lat, 4);
      chk("set_wen_cnt", wcnt, 1);
      chk("set_leds", leds, 4'hB);
      do_req(2'd3, 5'd1, 8'h03, r_d, lat, wcnt, wa, wd);
      void'(ref_exec(2'd3, 5'd1, 8'h03));
      chk("clr_resp", r_d, 8'h03);
      chk("clr_leds", leds, 4'h3);

      // Back-to-back: read addr 1 then write 0x06 to addr 1 with req_valid held
      req_op    = 2'd0;
      req_addr  = 5'd1;
      req_data  = 8'h00;
      req_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 req_op = 2'd1;
      req_data      = 8'h06;
      first_resp    = 0;
      second_resp   = 0;
      ready_at_resp = 1'b0;
      first_data    = 'x;
      second_data   = 'x;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (resp_valid && first_resp == 0) begin
            first_resp    = n;
            first_data    = resp_data;
            ready_at_resp = req_ready;
         end else if (resp_valid && second_resp == 0) begin
            second_resp = n;
            second_data = resp_data;
         end
         @(posedge clk);
         #1;
         if (n == 3) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      chk("b2b_rd_cycle", first_resp, 3);
      chk("b2b_rd_data", first_data, ref_exec(2'd0, 5'd1, 8'h00));
      chk("b2b_ready_on_resp", ready_at_resp, 1);
      chk("b2b_wr_cycle", second_resp, 5);
      chk("b2b_wr_data", second_data, ref_exec(2'd1, 5'd1, 8'h06));
      chk("b2b_leds", leds, 4'h6);

      // Reset asserted while a bit-set sits in the read-data phase
      req_op    = 2'd2;
      req_addr  = 5'd1;
      req_data  = 8'h03;
      req_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("abort_ready_in_rst", req_ready, 0);
      wcnt = write_en ? 1 : 0;
      rcnt = resp_valid ? 1 : 0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_ready_after", req_ready, 1);
      for (int n = 0; n < 5; n++) begin
         if (write_en) wcnt++;
         if (resp_valid) rcnt++;
         @(negedge clk);
      end
      chk("abort_wen", wcnt, 0);
      chk("abort_resp", rcnt, 0);
      chk("abort_leds", leds, ref_led);
      @(posedge clk);
      #1;

      // Randomized stream; request inputs change freely while the master is busy
      sw    = 4'($urandom);
      keys  = 4'($urandom);
      nacc  = 0;
      nresp = 0;
      pend  = 1'b0;
      age   = 0;
      wcnt  = 0;
      cyc   = 0;
      p_op  = '0;
      p_addr = '0;
      p_data = '0;
      while ((nresp < 100 || pend) && cyc < 3000) begin
         req_op    = 2'($urandom);
         req_addr  = ($urandom % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         req_data  = 8'($urandom);
         req_valid = (nacc < 100) && ($urandom % 4 != 0);
         @(negedge clk);
         cyc++;
         if (pend) begin
            age++;
            if (write_en) wcnt++;
         end else begin
            chk("rnd_idle_quiet", {resp_valid, write_en}, 2'b00);
         end
         if (pend && resp_valid) begin
            exp_v = ref_exec(p_op, p_addr, p_data);
            chk("rnd_resp_data", resp_data, exp_v);
            chk("rnd_latency", age, lat_of(p_op));
            chk("rnd_wen_cnt", wcnt, (p_op == 2'd0) ? 0 : 1);
            chk("rnd_ready_on_resp", req_ready, 1);
            pend = 1'b0;
            nresp++;
         end else if (pend && age >= 8) begin
            chk("rnd_timeout", age, lat_of(p_op));
            void'(ref_exec(p_op, p_addr, p_data));
            pend = 1'b0;
            nresp++;
         end
         accepting = req_valid && req_ready;
         if (accepting) begin
            chk("rnd_accept_idle", pend, 0);
            pend   = 1'b1;
            p_op   = req_op;
            p_addr = req_addr;
            p_data = req_data;
            age    = 0;
            wcnt   = 0;
            nacc++;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      chk("rnd_resp_count", nresp, 100);
      chk("rnd_accept_count", nacc, nresp);
      chk("rnd_leds", leds, ref_led);
      for (int i = 2; i < 16; i++) chk("rnd_reg", p_regs[i], ref_regs[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
